// File: rtl/dsm_cic_decimator_if.sv
//------------------------------------------------------------------------------
// Module   : dsm_cic_decimator_if
// Purpose  : Input strobe/word and output valid/ready bundle for the CIC decimator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dsm_cic_decimator_if #(
    parameter int IN_BW = 4,
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [IN_BW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             overrun;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/dsm_cic_decimator.sv
//------------------------------------------------------------------------------
// Module   : dsm_cic_decimator
// Purpose  : Third-order CIC decimator recovering PCM from a MASH word or DSM bitstream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsm_cic_decimator #(
    parameter int IN_BW      = 4,
    parameter int BITSTREAM  = 0,
    parameter int DECIM_LOG2 = 5,
    parameter int WIDTH      = 16
) (
    input  wire logic          aclk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    dsm_cic_decimator_if.slave bus
);
    localparam int ACC_W = IN_BW + 3 * DECIM_LOG2;

    localparam logic [0:0] c_ST_WARMUP = 1'b0;
    localparam logic [0:0] c_ST_RUN    = 1'b1;

    logic [ACC_W-1:0]      w_x;
    logic [ACC_W-1:0]      w_i1_nx;
    logic [ACC_W-1:0]      w_i2_nx;
    logic [ACC_W-1:0]      w_i3_nx;
    logic [ACC_W-1:0]      w_c1;
    logic [ACC_W-1:0]      w_c2;
    logic [ACC_W-1:0]      w_c3;
    logic [WIDTH-1:0]      w_res;
    logic                  w_take;
    logic                  w_last;
    logic                  w_load_cand;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_drop;
    logic                  w_unused_lsb;

    logic [ACC_W-1:0]      r_i1;
    logic [ACC_W-1:0]      r_i2;
    logic [ACC_W-1:0]      r_i3;
    logic [DECIM_LOG2-1:0] r_cnt;
    logic [ACC_W-1:0]      r_dec;
    logic                  r_dec_stb;
    logic [ACC_W-1:0]      r_d1;
    logic [ACC_W-1:0]      r_c1d;
    logic [ACC_W-1:0]      r_c2d;
    logic [0:0]            r_state;
    logic                  r_discard;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_overrun;

    generate
        if (BITSTREAM != 0) begin : g_bitstream
            logic w_unused_in;
            assign w_unused_in = ^bus.in_data;
            assign w_x = bus.in_data[0] ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
        end else begin : g_word
            assign w_x = {{(ACC_W-IN_BW){bus.in_data[IN_BW-1]}}, bus.in_data};
        end
    endgenerate

    // Integrators chain on the freshly updated value so DC settles inside the warm-up.
    assign w_i1_nx = r_i1 + w_x;
    assign w_i2_nx = r_i2 + w_i1_nx;
    assign w_i3_nx = r_i3 + w_i2_nx;
    assign w_take  = bus.in_valid & ~clear;
    assign w_last  = (r_cnt == {DECIM_LOG2{1'b1}});

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_i3      <= '0;
            r_cnt     <= '0;
            r_dec     <= '0;
            r_dec_stb <= 1'b0;
        end else if (clear) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_i3      <= '0;
            r_cnt     <= '0;
            r_dec     <= '0;
            r_dec_stb <= 1'b0;
        end else begin
            r_dec_stb <= w_take & w_last;
            if (w_take) begin
                r_i1  <= w_i1_nx;
                r_i2  <= w_i2_nx;
                r_i3  <= w_i3_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_dec <= w_i3_nx;
                end
            end
        end
    end

    // Comb differences are combinational so the result lands in the slot one cycle after the strobe.
    assign w_c1         = r_dec - r_d1;
    assign w_c2         = w_c1 - r_c1d;
    assign w_c3         = w_c2 - r_c2d;
    assign w_res        = w_c3[ACC_W-1 -: WIDTH];
    assign w_unused_lsb = ^w_c3;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1  <= '0;
            r_c1d <= '0;
            r_c2d <= '0;
        end else if (clear) begin
            r_d1  <= '0;
            r_c1d <= '0;
            r_c2d <= '0;
        end else if (r_dec_stb) begin
            r_d1  <= r_dec;
            r_c1d <= w_c1;
            r_c2d <= w_c2;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_WARMUP;
            r_discard <= 1'b0;
        end else if (clear) begin
            r_state   <= c_ST_WARMUP;
            r_discard <= 1'b0;
        end else if (r_dec_stb && (r_state == c_ST_WARMUP)) begin
            if (r_discard) begin
                r_state   <= c_ST_RUN;
                r_discard <= 1'b0;
            end else begin
                r_discard <= 1'b1;
            end
        end
    end

    assign w_load_cand = r_dec_stb & (r_state == c_ST_RUN);
    assign w_accept    = r_out_valid & bus.out_ready;
    assign w_load      = w_load_cand & (~r_out_valid | bus.out_ready);
    assign w_drop      = w_load_cand & r_out_valid & ~bus.out_ready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    // Overrun is sticky across clear; only reset removes it.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop && !clear) begin
            r_overrun <= 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: doc/dsm_cic_decimator.md
# dsm_cic_decimator

Receive-side counterpart of the MASH/DSM modulator chain: takes the oversampled modulator output and reconstructs PCM samples. The input is either the signed multi-bit MASH word or the 1-bit DSM bitstream. A third-order CIC decimator with decimation ratio 2**DECIM_LOG2 recovers WIDTH-bit samples. Results are delivered on a valid/ready output port, so modulator loopback benches can compare recovered samples against the NCO `tx_*_data` words.

## Interface
- `IN_BW`, 4, signed input word width (MASH word); minimum 2
- `BITSTREAM`, 0, 1: only `in_data[0]` is used (1 -> +1, 0 -> -1); 0: `in_data` is a signed two's-complement word
- `DECIM_LOG2`, 5, log2 of decimation ratio R (R = 32 by default); range 1..8
- `WIDTH`, 16, output sample width; must satisfy WIDTH <= ACC_W
- `ACC_W` (localparam) = IN_BW + 3*DECIM_LOG2 (19 by default)

Ports:
- `aclk`  in  1  sole clock; all logic is rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear of filter state and warm-up (does not clear `overrun`)
- `in_valid`  in  1  input sample strobe, one sample per asserted cycle
- `in_data`  in  IN_BW  signed modulator sample
- `out_valid`  out  1  output sample available
- `out_ready`  in  1  consumer accepts sample
- `out_data`  out  WIDTH  signed decimated sample
- `overrun`  out  1  sticky: a decimated result was dropped

## Operation
- Input mapping: sign-extend the mapped input to ACC_W bits. In BITSTREAM mode the mapped value is ±1.
- Integrators: I1 += x, I2 += I1, I3 += I2. All three update only on `in_valid` cycles and wrap modulo 2**ACC_W. The wrap is intentional and must not saturate.
- Decimation counter (DECIM_LOG2 bits) counts accepted inputs 0..R-1 and wraps. On an `in_valid` cycle with count == R-1, the post-update I3 value is captured into the decimation register and `dec_stb` pulses next cycle.
- Combs (on `dec_stb`, modulo 2**ACC_W): C1 = D − D1, C2 = C1 − C1d, C3 = C2 − C2d, where D1, C1d and C2d are delay registers updated on `dec_stb`.
- Scaling: result = C3[ACC_W-1 -: WIDTH], i.e. truncation. DC gain is R**3, so the default output equals x·4096.
- Warm-up FSM:
  - States are WARMUP and RUN.
  - WARMUP discards the first 2 comb results using a 1-bit discard counter, then moves to RUN.
  - RUN forwards every comb result to the output slot.
  - `clear` or reset returns to WARMUP.
- Output slot is a single register:
  - Load: a RUN result is loaded when the slot is empty or is being accepted in the same cycle. Loading sets `out_valid`.
  - Accept: `out_valid & out_ready` empties the slot unless a new result loads in the same cycle.
  - Drop: a result arriving while `out_valid & !out_ready` is dropped. The held sample is kept and `overrun` is set.
- `clear` zeroes integrators, combs, delays, the decimation counter and the output slot (`out_valid` = 0). It takes priority over a same-cycle `in_valid`, which is ignored.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `overrun` = 0. All integrators, combs, counters and the FSM state (WARMUP) are also reset.
- Latency, with cycle t being the `in_valid` cycle at count R-1:
  - `dec_stb` at t+1.
  - Comb result registered and `out_valid` high at t+2.
  - Latency is therefore 2 cycles from the last contributing input.
- `out_data` is stable while `out_valid & !out_ready`.
- Throughput: one output per R valid inputs. With `out_ready` tied high, `out_valid` is a 1-cycle pulse.
- `in_valid` may be asserted every cycle; gaps stall the integrators and the counter without affecting results.
- `rst_n` asserted mid-operation clears all state immediately (asynchronous). After release, the warm-up is repeated.

## Test plan
- DC multi-bit: defaults, `in_data` = +3 on every cycle from reset, `out_ready` = 1. The first `out_valid` follows input 96 by 2 cycles with `out_data` = 12288. Every following output is 12288, spaced 32 cycles apart.
- Extremes/wrap: `in_data` = −8 constant for 10000 cycles. Every output is −32768, with no corruption from integrator wraparound. Repeat with +7 -> 28672.
- Bitstream: BITSTREAM = 1 with alternating 1,0 -> all outputs 0. All ones -> 4096. Pattern 1,1,1,0 repeating -> 2048.
- Back-pressure: `out_ready` = 0 across two decimation periods. `out_valid` stays high and `out_data` holds the first sample. `overrun` goes to 1 at the second result and stays 1 after `out_ready` returns.
- Sparse input: `in_valid` at 1/3 duty, DC +1. Outputs are 4096, one per 96 cycles.
- Clear/reset mid-run: `clear` pulse or `rst_n` low during an output hold. `out_valid` drops, the next 2 results are discarded, and `overrun` survives `clear` but not `rst_n`.
